// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data memory bus between the load/store unit and data memory
interface DataMemoryBus #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wrData;
    logic                  wrEnable;
    logic [DATA_WIDTH-1:0] rdData;

    modport master (output addr, output wrData, output wrEnable, input rdData);
    modport slave  (input addr, input wrData, input wrEnable, output rdData);
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 byte/half/word load-store bus master with read-modify-write sub-word stores
module load_store_unit (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wrData,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_misaligned,
    output logic [31:0] o_rdData,
    DataMemoryBus.master bus
);
    localparam int ADDR_WIDTH = $bits(bus.addr);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RMW_WR
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [31:0]           wdata_q;
    logic                  accept;
    logic                  misaligned_req;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [31:0]           load_ext;
    logic [31:0]           merged;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_addr[31:ADDR_WIDTH+2];

    always_comb begin
        misaligned_req = 1'b0;
        case (i_size)
            2'b01:   misaligned_req = i_addr[0];
            2'b10:   misaligned_req = |i_addr[1:0];
            2'b11:   misaligned_req = 1'b1;
            default: misaligned_req = 1'b0;
        endcase
    end

    assign accept = i_req && o_ready;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept && !misaligned_req) begin
                    if (!i_we)                state_n = RD;
                    else if (i_size == 2'b10) state_n = WR;
                    else                      state_n = RMW_RD;
                end
            end
            RD:        state_n = RD_WAIT;
            RD_WAIT:   state_n = IDLE;
            WR:        state_n = IDLE;
            RMW_RD:    state_n = RMW_MERGE;
            RMW_MERGE: state_n = RMW_WR;
            RMW_WR:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Bus outputs decode only registered state, so i_req never reaches the bus combinationally.
    always_comb begin
        o_ready      = (state == IDLE) && i_reset;
        bus.addr     = '0;
        bus.wrData   = '0;
        bus.wrEnable = 1'b0;
        if (state != IDLE) begin
            bus.addr = addr_q[ADDR_WIDTH+1:2];
        end
        if (state == WR || state == RMW_WR) begin
            bus.wrData   = wdata_q;
            bus.wrEnable = 1'b1;
        end
    end

    always_comb begin
        byte_lane = bus.rdData[7:0];
        case (addr_q[1:0])
            2'd0: byte_lane = bus.rdData[7:0];
            2'd1: byte_lane = bus.rdData[15:8];
            2'd2: byte_lane = bus.rdData[23:16];
            2'd3: byte_lane = bus.rdData[31:24];
            default: byte_lane = bus.rdData[7:0];
        endcase
        half_lane = addr_q[1] ? bus.rdData[31:16] : bus.rdData[15:0];
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = unsigned_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = bus.rdData;
        endcase
    end

    // Old word with the addressed lane replaced by the right-aligned store data.
    always_comb begin
        merged = bus.rdData;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = bus.rdData;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            addr_q       <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_rdData     <= '0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            if (accept) begin
                addr_q     <= i_addr[ADDR_WIDTH+1:0];
                size_q     <= i_size;
                unsigned_q <= i_unsigned;
                wdata_q    <= i_wrData;
                if (misaligned_req) begin
                    o_done       <= 1'b1;
                    o_misaligned <= 1'b1;
                end
            end
            case (state)
                RD_WAIT: begin
                    o_rdData <= load_ext;
                    o_done   <= 1'b1;
                end
                WR:        o_done  <= 1'b1;
                RMW_MERGE: wdata_q <= merged;
                RMW_WR:    o_done  <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
